// File: rtl/vai_master.sv
// vai_master: VAI initiator. Serialises single host read/write commands into a
// VAI request frame, parses the returned ack frame and hands back data + status.
// Optional build macro: VAI_MASTER_TIMEOUT_EN (per-beat ack timeout, status 11).
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | waiting for a host command (or discarding a late ack frame)
//  TX_HDR   | presenting the request header beat
//  TX_DATA  | presenting the write data beat
//  RX_HDR   | waiting for the ack header beat
//  RX_DATA  | waiting for the ack read-data beat
//  RX_STOP  | waiting for the ack stop beat; also drains after a frame error
//  RSP      | presenting the result to the host
module vai_master #(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic       Clk_i,
    input  logic       Reset_n_i,
    input  logic       ReqValid_i,
    output logic       ReqAccept_o,
    input  logic       ReqWrite_i,
    input  logic [3:0] ReqAddr_i,
    input  logic [7:0] ReqData_i,
    output logic       RspValid_o,
    input  logic       RspAccept_i,
    output logic [7:0] RspData_o,
    output logic [1:0] RspStatus_o,
    output logic [7:0] Dout_o,
    output logic       DoutValid_o,
    output logic       DoutStart_o,
    output logic       DoutStop_o,
    input  logic       DoutAccept_i,
    input  logic [7:0] Din_i,
    input  logic       DinValid_i,
    input  logic       DinStart_i,
    input  logic       DinStop_i,
    output logic       DinAccept_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX_HDR  = 3'd1,
        S_TX_DATA = 3'd2,
        S_RX_HDR  = 3'd3,
        S_RX_DATA = 3'd4,
        S_RX_STOP = 3'd5,
        S_RSP     = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_hdr;
    logic [7:0] r_wdata;
    logic [7:0] r_data;
    logic       r_ferr;
    logic       r_rerr;
    logic       r_tmo;
    logic       r_run;
    logic       w_write;
    logic       w_in_rx;
    logic       w_beat;
    logic       w_hdr_bad;
    logic       w_timeout;
    logic       w_discard;

    assign w_write   = r_hdr[0];
    assign w_in_rx   = (r_state == S_RX_HDR) || (r_state == S_RX_DATA) || (r_state == S_RX_STOP);
    assign w_beat    = DinValid_i && DinAccept_o;
    // Upper nibble of the ack header is the responder's echo of the address; only cmd is checked.
    assign w_hdr_bad = !DinStart_i || DinStop_i || (Din_i[3:0] != r_hdr[3:0]);

`ifdef VAI_MASTER_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_discard;

    assign w_timeout = w_in_rx && !w_beat && (r_cnt == 16'(RSP_TIMEOUT - 1));
    assign w_discard = r_discard;

    // Per-beat wait counter: restarts on every RX state entry and every accepted ack beat.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_cnt <= 16'd0;
        end else if (!w_in_rx || (w_state_nxt != r_state) || w_beat) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // After a timeout the late ack frame is swallowed in IDLE up to its stop beat.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_discard <= 1'b0;
        end else if (w_timeout) begin
            r_discard <= 1'b1;
        end else if ((r_state == S_IDLE) && w_beat && DinStop_i) begin
            r_discard <= 1'b0;
        end
    end
`else
    localparam int unsigned LP_UNUSED_TMO = RSP_TIMEOUT;
    assign w_timeout = 1'b0;
    assign w_discard = 1'b0;
`endif

    // State register; r_run keeps ReqAccept_o low while reset is asserted.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // Next-state and beat-level handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ReqAccept_o = 1'b0;
        DoutValid_o = 1'b0;
        DoutStart_o = 1'b0;
        DoutStop_o  = 1'b0;
        Dout_o      = 8'h00;
        DinAccept_o = 1'b0;
        RspValid_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ReqAccept_o = r_run && !w_discard;
                DinAccept_o = w_discard;
                if (ReqValid_i && ReqAccept_o) begin
                    w_state_nxt = S_TX_HDR;
                end
            end
            S_TX_HDR: begin
                DoutValid_o = 1'b1;
                DoutStart_o = 1'b1;
                DoutStop_o  = !w_write;
                Dout_o      = r_hdr;
                if (DoutAccept_i) begin
                    w_state_nxt = w_write ? S_TX_DATA : S_RX_HDR;
                end
            end
            S_TX_DATA: begin
                DoutValid_o = 1'b1;
                DoutStop_o  = 1'b1;
                Dout_o      = r_wdata;
                if (DoutAccept_i) begin
                    w_state_nxt = S_RX_HDR;
                end
            end
            S_RX_HDR: begin
                DinAccept_o = 1'b1;
                if (w_beat) begin
                    if (DinStop_i) begin
                        w_state_nxt = S_RSP;
                    end else begin
                        w_state_nxt = w_write ? S_RX_STOP : S_RX_DATA;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RX_DATA: begin
                DinAccept_o = 1'b1;
                if (w_beat) begin
                    w_state_nxt = DinStop_i ? S_RSP : S_RX_STOP;
                end else if (w_timeout) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RX_STOP: begin
                DinAccept_o = 1'b1;
                if ((w_beat && DinStop_i) || w_timeout) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                RspValid_o = 1'b1;
                if (RspAccept_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, ack parsing and error flags.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_hdr   <= 8'h00;
            r_wdata <= 8'h00;
            r_data  <= 8'h00;
            r_ferr  <= 1'b0;
            r_rerr  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ReqValid_i && ReqAccept_o) begin
                        r_hdr   <= {ReqAddr_i, 3'b000, ReqWrite_i};
                        r_wdata <= ReqData_i;
                        r_data  <= 8'h00;
                        r_ferr  <= 1'b0;
                        r_rerr  <= 1'b0;
                        r_tmo   <= 1'b0;
                    end
                end
                S_RX_HDR: begin
                    if (w_beat && w_hdr_bad) begin
                        r_ferr <= 1'b1;
                    end
                end
                S_RX_DATA: begin
                    if (w_beat) begin
                        r_data <= Din_i;
                        if (DinStart_i || DinStop_i) begin
                            r_ferr <= 1'b1;
                        end
                    end
                end
                S_RX_STOP: begin
                    if (w_beat) begin
                        if (!DinStop_i || (Din_i > 8'h01)) begin
                            r_ferr <= 1'b1;
                        end else if (Din_i == 8'h01) begin
                            r_rerr <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
            if (w_timeout) begin
                r_tmo  <= 1'b1;
                r_data <= 8'h00;
            end
        end
    end

    // Result is only driven while presenting it; timeout > frame error > responder error.
    always_comb begin
        RspData_o   = 8'h00;
        RspStatus_o = 2'b00;
        if (r_state == S_RSP) begin
            RspData_o = r_data;
            if (r_tmo) begin
                RspStatus_o = 2'b11;
            end else if (r_ferr) begin
                RspStatus_o = 2'b10;
            end else if (r_rerr) begin
                RspStatus_o = 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_vai_master.sv
// tb_vai_master: randomized scoreboard bench for vai_master.
// Expected request beats and results are queued when a command is issued;
// independent monitors pop and compare whenever the DUT presents them.
module tb_vai_master;

    localparam int TMO = 8;

    logic       Clk_i = 1'b0;
    logic       Reset_n_i = 1'b0;
    logic       ReqValid_i = 1'b0;
    logic       ReqAccept_o;
    logic       ReqWrite_i = 1'b0;
    logic [3:0] ReqAddr_i = 4'h0;
    logic [7:0] ReqData_i = 8'h00;
    logic       RspValid_o;
    logic       RspAccept_i = 1'b0;
    logic [7:0] RspData_o;
    logic [1:0] RspStatus_o;
    logic [7:0] Dout_o;
    logic       DoutValid_o;
    logic       DoutStart_o;
    logic       DoutStop_o;
    logic       DoutAccept_i = 1'b0;
    logic [7:0] Din_i = 8'h00;
    logic       DinValid_i = 1'b0;
    logic       DinStart_i = 1'b0;
    logic       DinStop_i = 1'b0;
    logic       DinAccept_o;

    vai_master #(.RSP_TIMEOUT(TMO)) dut (
        .Clk_i        (Clk_i),
        .Reset_n_i    (Reset_n_i),
        .ReqValid_i   (ReqValid_i),
        .ReqAccept_o  (ReqAccept_o),
        .ReqWrite_i   (ReqWrite_i),
        .ReqAddr_i    (ReqAddr_i),
        .ReqData_i    (ReqData_i),
        .RspValid_o   (RspValid_o),
        .RspAccept_i  (RspAccept_i),
        .RspData_o    (RspData_o),
        .RspStatus_o  (RspStatus_o),
        .Dout_o       (Dout_o),
        .DoutValid_o  (DoutValid_o),
        .DoutStart_o  (DoutStart_o),
        .DoutStop_o   (DoutStop_o),
        .DoutAccept_i (DoutAccept_i),
        .Din_i        (Din_i),
        .DinValid_i   (DinValid_i),
        .DinStart_i   (DinStart_i),
        .DinStop_i    (DinStop_i),
        .DinAccept_o  (DinAccept_o)
    );

    always #5 Clk_i = ~Clk_i;

    logic [23:0] w_outs;
    assign w_outs = {ReqAccept_o, RspValid_o, RspData_o, RspStatus_o, Dout_o,
                     DoutValid_o, DoutStart_o, DoutStop_o, DinAccept_o};

    typedef struct {
        logic [7:0] b;
        logic       st;
        logic       sp;
    } beat_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
        bit         chk_d;
    } rsp_t;

    beat_t exp_req[$];
    rsp_t  exp_rsp[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    acc_mode = 0;   // 0 always accept, 1 random, 2 stall 4 per beat, 3 never
    int    stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got nothing expected an event", name);
    endtask

    function automatic beat_t mk(input logic [7:0] b, input logic st, input logic sp);
        beat_t r;
        r.b  = b;
        r.st = st;
        r.sp = sp;
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    // Responder-side acceptance of request beats.
    always begin
        @(posedge Clk_i);
        #1;
        case (acc_mode)
            0: DoutAccept_i = 1'b1;
            1: DoutAccept_i = ($urandom_range(0, 3) != 0);
            2: begin
                if (DoutValid_o && stall_cnt < 4) begin
                    DoutAccept_i = 1'b0;
                    stall_cnt++;
                end else begin
                    DoutAccept_i = DoutValid_o;
                    stall_cnt = 0;
                end
            end
            default: DoutAccept_i = 1'b0;
        endcase
    end

    // Request monitor: beat order/content and hold-while-stalled.
    logic [9:0] prev_out;
    bit         prev_stall = 1'b0;
    always @(negedge Clk_i) begin : mon_req
        beat_t e;
        if (Reset_n_i) begin
            if (prev_stall)
                check("dout_hold", {DoutValid_o, DoutStart_o, DoutStop_o, Dout_o}, {1'b1, prev_out});
            if (DoutValid_o && DoutAccept_i) begin
                if (exp_req.size() == 0) begin
                    fail_now("req_beat_unexpected");
                end else begin
                    e = exp_req.pop_front();
                    check("req_beat", {DoutStart_o, DoutStop_o, Dout_o}, {e.st, e.sp, e.b});
                end
            end
            prev_stall = DoutValid_o && !DoutAccept_i;
            prev_out   = {DoutStart_o, DoutStop_o, Dout_o};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Result monitor.
    always @(negedge Clk_i) begin : mon_rsp
        rsp_t e;
        if (Reset_n_i && RspValid_o && RspAccept_i) begin
            if (exp_rsp.size() == 0) begin
                fail_now("rsp_unexpected");
            end else begin
                e = exp_rsp.pop_front();
                check("rsp_status", RspStatus_o, e.s);
                if (e.chk_d) check("rsp_data", RspData_o, e.d);
            end
        end
    end

    task automatic issue(input bit wr, input logic [3:0] a, input logic [7:0] d);
        int n;
        n = 0;
        ReqValid_i = 1'b1;
        ReqWrite_i = wr;
        ReqAddr_i  = a;
        ReqData_i  = d;
        @(negedge Clk_i);
        while (!ReqAccept_o && n < 200) begin
            @(negedge Clk_i);
            n++;
        end
        if (!ReqAccept_o) begin
            fail_now("req_accept_timeout");
        end else begin
            exp_req.push_back(mk({a, 3'b000, wr}, 1'b1, !wr));
            if (wr) exp_req.push_back(mk(d, 1'b0, 1'b1));
        end
        tick();
        ReqValid_i = 1'b0;
        ReqWrite_i = 1'b0;
        ReqAddr_i  = 4'h0;
        ReqData_i  = 8'h00;
    endtask

    task automatic send_ack(input beat_t fr[$]);
        foreach (fr[i]) begin
            int n;
            n = 0;
            repeat ($urandom_range(0, 2)) tick();
            Din_i      = fr[i].b;
            DinStart_i = fr[i].st;
            DinStop_i  = fr[i].sp;
            DinValid_i = 1'b1;
            @(negedge Clk_i);
            while (!DinAccept_o && n < 200) begin
                @(negedge Clk_i);
                n++;
            end
            if (!DinAccept_o) fail_now("ack_accept_timeout");
            tick();
            DinValid_i = 1'b0;
            DinStart_i = 1'b0;
            DinStop_i  = 1'b0;
            Din_i      = 8'h00;
        end
    endtask

    task automatic get_rsp(input bit chk_b2b);
        int n;
        n = 0;
        @(negedge Clk_i);
        while (!RspValid_o && n < 200) begin
            @(negedge Clk_i);
            n++;
        end
        if (!RspValid_o) begin
            fail_now("rsp_valid_timeout");
        end else begin
            repeat ($urandom_range(0, 2)) @(negedge Clk_i);
            @(posedge Clk_i);
            #1;
            RspAccept_i = 1'b1;
            tick();
            RspAccept_i = 1'b0;
            if (chk_b2b) check("b2b_accept", ReqAccept_o, 1);
        end
    endtask

    // Reference: responder echoes {addr, cmd}; addr > 7 answers stop 01.
    // cat 0 well-formed, 1 wrong cmd, 2 bad stop byte, 3 extra beat before stop,
    // 4 header carrying stop, 5 wrong cmd then immediate stop.
    task automatic txn(input bit wr, input logic [3:0] a, input logic [7:0] d,
                       input int cat, input logic [7:0] rd, input logic [7:0] sb);
        beat_t      fr[$];
        rsp_t       r;
        logic [3:0] cmd;
        logic [7:0] good_stop;
        cmd       = {3'b000, wr};
        good_stop = (a > 4'd7) ? 8'h01 : 8'h00;
        issue(wr, a, d);
        r.d     = wr ? 8'h00 : rd;
        r.s     = (a > 4'd7) ? 2'b01 : 2'b00;
        r.chk_d = 1'b1;
        if (cat != 0) begin
            r.s     = 2'b10;
            r.chk_d = 1'b0;
        end
        case (cat)
            4: fr.push_back(mk({a, cmd}, 1'b1, 1'b1));
            5: begin
                fr.push_back(mk({a, cmd ^ 4'h1}, 1'b1, 1'b0));
                fr.push_back(mk(8'h00, 1'b0, 1'b1));
            end
            default: begin
                fr.push_back(mk({a, (cat == 1) ? (cmd ^ 4'h1) : cmd}, 1'b1, 1'b0));
                if (!wr) fr.push_back(mk(rd, 1'b0, 1'b0));
                if (cat == 3) fr.push_back(mk(8'h77, 1'b0, 1'b0));
                fr.push_back(mk((cat == 2) ? sb : good_stop, 1'b0, 1'b1));
            end
        endcase
        exp_rsp.push_back(r);
        send_ack(fr);
        get_rsp(1'b1);
    endtask

    initial begin
        repeat (3) @(posedge Clk_i);
        #1;
        check("reset_outputs", w_outs, 0);
        Reset_n_i = 1'b1;
        tick();
        check("idle_accept", ReqAccept_o, 1);

        acc_mode = 0;
        txn(1'b1, 4'h3, 8'hA5, 0, 8'h00, 8'h00);
        txn(1'b0, 4'h5, 8'h00, 0, 8'h3C, 8'h00);
        txn(1'b1, 4'h9, 8'h66, 0, 8'h00, 8'h00);

        acc_mode = 2;
        txn(1'b1, 4'h6, 8'h5A, 0, 8'h00, 8'h00);
        txn(1'b0, 4'h4, 8'h00, 0, 8'hC3, 8'h00);
        acc_mode = 0;

        txn(1'b0, 4'h2, 8'h00, 5, 8'h00, 8'h00);
        txn(1'b0, 4'h2, 8'h00, 0, 8'h81, 8'h00);
        txn(1'b1, 4'hC, 8'h11, 2, 8'h00, 8'h01 + 8'h01);
        txn(1'b1, 4'hA, 8'h22, 3, 8'h00, 8'h00);
        txn(1'b0, 4'hE, 8'h00, 0, 8'h9E, 8'h00);

        acc_mode = 1;
        for (int k = 0; k < 150; k++) begin
            int cat;
            cat = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 5));
            txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                cat, 8'($urandom_range(0, 255)), 8'($urandom_range(2, 255)));
        end

        // Reset in the middle of a stalled request frame.
        acc_mode = 3;
        issue(1'b1, 4'h7, 8'h11);
        repeat (2) tick();
        check("pre_rst_valid", DoutValid_o, 1);
        Reset_n_i = 1'b0;
        #1;
        check("midrst_outputs", w_outs, 0);
        exp_req.delete();
        exp_rsp.delete();
        tick();
        Reset_n_i = 1'b1;
        acc_mode = 0;
        repeat (2) tick();
        txn(1'b0, 4'h1, 8'h00, 0, 8'h5B, 8'h00);

`ifdef VAI_MASTER_TIMEOUT_EN
        begin
            int    n;
            rsp_t  r;
            beat_t fr[$];
            n = 0;
            issue(1'b0, 4'h1, 8'h00);
            r.d     = 8'h00;
            r.s     = 2'b11;
            r.chk_d = 1'b1;
            exp_rsp.push_back(r);
            tick();
            while (!RspValid_o && n < 100) begin
                tick();
                n++;
            end
            check("tmo_cycles", n, TMO);
            get_rsp(1'b0);
            check("tmo_blocked", ReqAccept_o, 0);
            fr.push_back(mk(8'h10, 1'b1, 1'b0));
            fr.push_back(mk(8'h00, 1'b0, 1'b1));
            send_ack(fr);
            check("tmo_unblock", ReqAccept_o, 1);
        end
`endif

        repeat (3) tick();
        check("req_queue_drained", exp_req.size(), 0);
        check("rsp_queue_drained", exp_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
